// File: rtl/axis_pattern_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axis_pattern_gen_pkg
//  Purpose  : Shared encodings for the AXI4-Stream pattern generator and its
//             companion stream checker: MODE codes, LFSR polynomial, FSM type
//             and the single-step LFSR helper.
//  Revision : 1.0  initial release
// ============================================================================
package axis_pattern_gen_pkg;

    // Pattern select encodings
    localparam logic [1:0] MODE_CNT  = 2'd0;
    localparam logic [1:0] MODE_LFSR = 2'd1;
    localparam logic [1:0] MODE_WALK = 2'd2;
    localparam logic [1:0] MODE_ALT  = 2'd3;

    // Galois taps for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    // Generator FSM states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // One Galois step: shift right, fold the ejected bit back through the taps
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0000_0000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pattern_lfsr.sv
`default_nettype none
// ============================================================================
//  Module   : pattern_lfsr
//  Purpose  : 32-bit Galois LFSR with seed parameter and advance enable.
//             Shared between the pattern generator and the stream checker so
//             both sides step through an identical sequence.
//  Revision : 1.0  initial release
// ============================================================================
module pattern_lfsr
    import axis_pattern_gen_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_adv,
    output logic [31:0] o_state
);

    logic [31:0] state_q;
    logic [31:0] state_d;

    // Step once per enabled cycle, otherwise hold
    always_comb begin
        state_d = i_adv ? lfsr_next(state_q) : state_q;
    end

    // Register the LFSR state; reset loads the seed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign o_state = state_q;

endmodule
`default_nettype wire

// File: rtl/axis_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : axis_pattern_gen
//  Purpose  : AXI4-Stream test-pattern source with TREADY backpressure,
//             TLAST packet framing, four pattern modes and status counters.
//             Optional build macro AXIS_PATTERN_GEN_HDR_EN prefixes every
//             packet with a header beat {PKT_CNT[15:0], PKT_LEN[15:0]}
//             (requires DATA_WIDTH >= 32).
//  Revision : 1.0  initial release
// ============================================================================
module axis_pattern_gen
    import axis_pattern_gen_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          LEN_WIDTH  = 16,
    parameter logic [31:0] LFSR_SEED  = 32'h0000_0001
) (
    input  logic                  ACLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic [1:0]            MODE,
    input  logic [LEN_WIDTH-1:0]  PKT_LEN,
    output logic [DATA_WIDTH-1:0] TDATA,
    output logic                  TVALID,
    input  logic                  TREADY,
    output logic                  TLAST,
    output logic                  BUSY,
    output logic [31:0]           PKT_CNT,
    output logic [31:0]           BEAT_CNT
);

    localparam int NBYTES = DATA_WIDTH / 8;

    // Build one output word from the selected generator's state
    function automatic logic [DATA_WIDTH-1:0] pattern_word(
        input logic [1:0]            mode,
        input logic [DATA_WIDTH-1:0] cnt,
        input logic [31:0]           lfsr,
        input logic [DATA_WIDTH-1:0] walk,
        input logic                  alt
    );
        logic [DATA_WIDTH-1:0] w;
        w = '0;
        case (mode)
            MODE_CNT:  w = cnt;
            MODE_LFSR: begin
                // Replicate the 32-bit LFSR across the word (LSBs when narrower)
                for (int i = 0; i < DATA_WIDTH; i++) begin
                    w[i] = lfsr[i % 32];
                end
            end
            MODE_WALK: w = walk;
            default:   w = {NBYTES{alt ? 8'hAA : 8'h55}};
        endcase
        return w;
    endfunction

    // Index of the final beat; a zero length behaves as a one-beat packet
    function automatic logic [LEN_WIDTH-1:0] last_index(input logic [LEN_WIDTH-1:0] len);
        return (len == '0) ? '0 : len - 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t                state_q,    state_d;
    logic [1:0]            mode_q,     mode_d;
    logic [LEN_WIDTH-1:0]  len_q,      len_d;
    logic [LEN_WIDTH-1:0]  beat_idx_q, beat_idx_d;
    logic [DATA_WIDTH-1:0] tdata_q,    tdata_d;
    logic                  tvalid_q,   tvalid_d;
    logic                  tlast_q,    tlast_d;
    logic [31:0]           pkt_cnt_q,  pkt_cnt_d;
    logic [31:0]           beat_cnt_q, beat_cnt_d;

    // Pattern generator state
    logic [DATA_WIDTH-1:0] cnt_q,  cnt_d;
    logic [DATA_WIDTH-1:0] walk_q, walk_d;
    logic                  alt_q,  alt_d;   // 0 -> 0x55 bytes, 1 -> 0xAA bytes
    logic [31:0]           lfsr_q, lfsr_d;

    logic accept;      // beat handed to the sink this edge
    logic hdr_beat;    // current beat is a header (never advances generators)
    logic gen_adv;     // an accepted pattern beat
    logic start;       // a new packet begins at this edge

    assign accept = tvalid_q && TREADY;

`ifdef AXIS_PATTERN_GEN_HDR_EN
    assign hdr_beat = (beat_idx_q == '0);
`else
    assign hdr_beat = 1'b0;
`endif

    assign gen_adv = (state_q == SEND) && accept && !hdr_beat;

    // Shared LFSR engine; advances only when LFSR mode consumes a beat
    pattern_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (ACLK),
        .rst     (RST),
        .i_adv   (gen_adv && (mode_q == MODE_LFSR)),
        .o_state (lfsr_q)
    );

    // Post-edge generator values: only the latched mode's generator steps
    always_comb begin
        cnt_d  = cnt_q;
        walk_d = walk_q;
        alt_d  = alt_q;
        lfsr_d = lfsr_q;
        if (gen_adv) begin
            case (mode_q)
                MODE_CNT:  cnt_d  = cnt_q + 1'b1;
                MODE_LFSR: lfsr_d = lfsr_next(lfsr_q);
                MODE_WALK: walk_d = {walk_q[DATA_WIDTH-2:0], walk_q[DATA_WIDTH-1]};
                default:   alt_d  = ~alt_q;
            endcase
        end
    end

    // Packet sequencing: next-state, framing and the next output word
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        len_d      = len_q;
        beat_idx_d = beat_idx_q;
        tdata_d    = tdata_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        pkt_cnt_d  = pkt_cnt_q;
        beat_cnt_d = beat_cnt_q;
        start      = 1'b0;

        case (state_q)
            IDLE: begin
                if (EN) begin
                    start = 1'b1;
                end
            end
            default: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + 32'd1;
                    if (tlast_q) begin
                        pkt_cnt_d = pkt_cnt_q + 32'd1;
                        if (EN) begin
                            // Back-to-back: next packet starts with no TVALID gap
                            start = 1'b1;
                        end else begin
                            state_d  = IDLE;
                            tvalid_d = 1'b0;
                            tlast_d  = 1'b0;
                        end
                    end else begin
                        beat_idx_d = beat_idx_q + 1'b1;
                        tlast_d    = ((beat_idx_q + 1'b1) == last_index(len_q));
                        tdata_d    = pattern_word(mode_q, cnt_d, lfsr_d, walk_d, alt_d);
                    end
                end
            end
        endcase

        // Packet start: latch MODE/PKT_LEN and present the first beat
        if (start) begin
            state_d    = SEND;
            mode_d     = MODE;
            len_d      = PKT_LEN;
            beat_idx_d = '0;
            tvalid_d   = 1'b1;
            tlast_d    = (PKT_LEN <= LEN_WIDTH'(1));
`ifdef AXIS_PATTERN_GEN_HDR_EN
            tdata_d    = DATA_WIDTH'({pkt_cnt_d[15:0], 16'(PKT_LEN)});
`else
            tdata_d    = pattern_word(MODE, cnt_d, lfsr_d, walk_d, alt_d);
`endif
        end
    end

    // FSM and registered stream outputs
    always_ff @(posedge ACLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            mode_q     <= MODE_CNT;
            len_q      <= '0;
            beat_idx_q <= '0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            pkt_cnt_q  <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            len_q      <= len_d;
            beat_idx_q <= beat_idx_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            pkt_cnt_q  <= pkt_cnt_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Pattern generator registers; state persists across packets
    always_ff @(posedge ACLK or posedge RST) begin
        if (RST) begin
            cnt_q  <= '0;
            walk_q <= DATA_WIDTH'(1);
            alt_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            walk_q <= walk_d;
            alt_q  <= alt_d;
        end
    end

    assign TDATA    = tdata_q;
    assign TVALID   = tvalid_q;
    assign TLAST    = tlast_q;
    assign BUSY     = (state_q == SEND);
    assign PKT_CNT  = pkt_cnt_q;
    assign BEAT_CNT = beat_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_pattern_gen
//  Purpose  : Self-checking bench for axis_pattern_gen (32-bit and 8-bit
//             instances) against a behavioural packet/pattern model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axis_pattern_gen;

    logic        ACLK = 1'b0;
    logic        RST  = 1'b1;

    // 32-bit instance
    logic        en = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] pkt_len = 16'd0;
    logic        tready = 1'b0;
    logic [31:0] tdata;
    logic        tvalid, tlast, busy;
    logic [31:0] pkt_cnt, beat_cnt;

    // 8-bit instance
    logic        en8 = 1'b0;
    logic [1:0]  mode8 = 2'd0;
    logic [15:0] len8 = 16'd0;
    logic        tready8 = 1'b0;
    logic [7:0]  tdata8;
    logic        tvalid8, tlast8, busy8;
    logic [31:0] pkt_cnt8, beat_cnt8;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 ACLK = ~ACLK;

    axis_pattern_gen #(.DATA_WIDTH(32), .LEN_WIDTH(16), .LFSR_SEED(32'h0000_0001)) dut (
        .ACLK(ACLK), .RST(RST), .EN(en), .MODE(mode), .PKT_LEN(pkt_len),
        .TDATA(tdata), .TVALID(tvalid), .TREADY(tready), .TLAST(tlast),
        .BUSY(busy), .PKT_CNT(pkt_cnt), .BEAT_CNT(beat_cnt)
    );

    axis_pattern_gen #(.DATA_WIDTH(8), .LEN_WIDTH(16), .LFSR_SEED(32'h0000_0001)) dut8 (
        .ACLK(ACLK), .RST(RST), .EN(en8), .MODE(mode8), .PKT_LEN(len8),
        .TDATA(tdata8), .TVALID(tvalid8), .TREADY(tready8), .TLAST(tlast8),
        .BUSY(busy8), .PKT_CNT(pkt_cnt8), .BEAT_CNT(beat_cnt8)
    );

    // ---------------- reference model (32-bit instance) ----------------
    bit [31:0]   m_cnt, m_lfsr, m_walk;
    bit          m_alt;
    int unsigned m_pkt, m_beat;
    bit [7:0]    m8_walk;

    function automatic bit [31:0] lfsr_step(input bit [31:0] s);
        bit [31:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    function automatic bit [31:0] exp_word(input bit [1:0] md);
        case (md)
            2'd0:    return m_cnt;
            2'd1:    return m_lfsr;
            2'd2:    return m_walk;
            default: return m_alt ? 32'hAAAA_AAAA : 32'h5555_5555;
        endcase
    endfunction

    task automatic m_advance(input bit [1:0] md);
        case (md)
            2'd0:    m_cnt  = m_cnt + 1;
            2'd1:    m_lfsr = lfsr_step(m_lfsr);
            2'd2:    m_walk = {m_walk[30:0], m_walk[31]};
            default: m_alt  = ~m_alt;
        endcase
    endtask

    task automatic do_reset();
        @(negedge ACLK);
        RST = 1'b1; en = 1'b0; en8 = 1'b0; tready = 1'b0; tready8 = 1'b0;
        @(negedge ACLK);
        RST = 1'b0;
        m_cnt = 0; m_lfsr = 32'h1; m_walk = 32'h1; m_alt = 1'b0;
        m_pkt = 0; m_beat = 0; m8_walk = 8'h01;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge ACLK);
        RST = 1'b1;
        #1;
        n_tests++;
        if ({tvalid, tlast, busy, tdata, pkt_cnt, beat_cnt} !== 99'd0) begin
            n_fail++;
            $display("FAIL reset32: got v=%b l=%b b=%b d=%h p=%0d n=%0d required all zero",
                     tvalid, tlast, busy, tdata, pkt_cnt, beat_cnt);
        end
        n_tests++;
        if ({tvalid8, tlast8, busy8, tdata8} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset8: got v=%b l=%b b=%b d=%h required all zero",
                     tvalid8, tlast8, busy8, tdata8);
        end
        do_reset();
    endtask

    task automatic test_single_packet();
        do_reset();
        @(negedge ACLK); en = 1'b1; mode = 2'd0; pkt_len = 16'd4; tready = 1'b1;
        @(negedge ACLK); en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if ({tvalid, busy, tlast, tdata} !== {1'b1, 1'b1, (i == 3), exp_word(2'd0)}) begin
                n_fail++;
                $display("FAIL single_beat%0d: got v=%b b=%b l=%b d=%h required v=1 b=1 l=%b d=%h",
                         i, tvalid, busy, tlast, tdata, (i == 3), exp_word(2'd0));
            end
            m_advance(2'd0); m_beat++;
            if (i == 3) m_pkt++;
            @(negedge ACLK);
        end
        n_tests++;
        if ({tvalid, busy, pkt_cnt, beat_cnt} !== {1'b0, 1'b0, 32'd1, 32'd4}) begin
            n_fail++;
            $display("FAIL single_end: got v=%b b=%b p=%0d n=%0d required v=0 b=0 p=1 n=4",
                     tvalid, busy, pkt_cnt, beat_cnt);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge ACLK); en = 1'b1; mode = 2'd0; pkt_len = 16'd3; tready = 1'b1;
        @(negedge ACLK);
        for (int i = 0; i < 9; i++) begin
            n_tests++;
            if ({tvalid, tlast, tdata} !== {1'b1, (i % 3 == 2), exp_word(2'd0)}) begin
                n_fail++;
                $display("FAIL b2b_beat%0d: got v=%b l=%b d=%h required v=1 l=%b d=%h",
                         i, tvalid, tlast, tdata, (i % 3 == 2), exp_word(2'd0));
            end
            m_advance(2'd0); m_beat++;
            if (i % 3 == 2) begin
                m_pkt++;
                mode = 2'd0; pkt_len = 16'd3;   // values re-latched at this edge
            end else begin
                mode = 2'($urandom_range(1, 3)); pkt_len = 16'($urandom_range(0, 9));
            end
            if (i == 8) en = 1'b0;
            @(negedge ACLK);
        end
        n_tests++;
        if ({tvalid, pkt_cnt, beat_cnt} !== {1'b0, 32'd3, 32'd9}) begin
            n_fail++;
            $display("FAIL b2b_end: got v=%b p=%0d n=%0d required v=0 p=3 n=9",
                     tvalid, pkt_cnt, beat_cnt);
        end
    endtask

    task automatic test_lfsr_stall();
        int idx = 0;
        int cyc = 0;
        bit [3:0] pat = 4'b1001;   // TREADY 1,0,0,1 (bit index = cyc % 4)
        do_reset();
        @(negedge ACLK); en = 1'b1; mode = 2'd1; pkt_len = 16'd8; tready = 1'b1;
        @(negedge ACLK); en = 1'b0;
        while (idx < 8 && cyc < 200) begin
            mode = 2'($urandom_range(0, 3));
            n_tests++;
            if ({tvalid, busy, tlast, tdata} !== {1'b1, 1'b1, (idx == 7), exp_word(2'd1)}) begin
                n_fail++;
                $display("FAIL lfsr_beat%0d_cyc%0d: got v=%b b=%b l=%b d=%h required v=1 b=1 l=%b d=%h",
                         idx, cyc, tvalid, busy, tlast, tdata, (idx == 7), exp_word(2'd1));
            end
            tready = pat[cyc % 4];
            if (tready) begin
                m_advance(2'd1); m_beat++; idx++;
                if (idx == 8) m_pkt++;
            end
            cyc++;
            @(negedge ACLK);
        end
        n_tests++;
        if (idx != 8) begin
            n_fail++;
            $display("FAIL lfsr_timeout: got %0d beats required 8", idx);
        end
        n_tests++;
        if ({tvalid, pkt_cnt, beat_cnt} !== {1'b0, 32'd1, 32'd8}) begin
            n_fail++;
            $display("FAIL lfsr_end: got v=%b p=%0d n=%0d required v=0 p=1 n=8",
                     tvalid, pkt_cnt, beat_cnt);
        end
    endtask

    task automatic test_walk8();
        do_reset();
        @(negedge ACLK); en8 = 1'b1; mode8 = 2'd2; len8 = 16'd10; tready8 = 1'b1;
        @(negedge ACLK); en8 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if ({tvalid8, tlast8, tdata8} !== {1'b1, (i == 9), m8_walk}) begin
                n_fail++;
                $display("FAIL walk8_beat%0d: got v=%b l=%b d=%h required v=1 l=%b d=%h",
                         i, tvalid8, tlast8, tdata8, (i == 9), m8_walk);
            end
            m8_walk = {m8_walk[6:0], m8_walk[7]};
            @(negedge ACLK);
        end
        n_tests++;
        if ({tvalid8, pkt_cnt8, beat_cnt8} !== {1'b0, 32'd1, 32'd10}) begin
            n_fail++;
            $display("FAIL walk8_end: got v=%b p=%0d n=%0d required v=0 p=1 n=10",
                     tvalid8, pkt_cnt8, beat_cnt8);
        end
    endtask

    task automatic test_len0_alt();
        do_reset();
        @(negedge ACLK); en = 1'b1; mode = 2'd3; pkt_len = 16'd0; tready = 1'b1;
        @(negedge ACLK);
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if ({tvalid, tlast, tdata, pkt_cnt} !== {1'b1, 1'b1, exp_word(2'd3), 32'(m_pkt)}) begin
                n_fail++;
                $display("FAIL len0_beat%0d: got v=%b l=%b d=%h p=%0d required v=1 l=1 d=%h p=%0d",
                         i, tvalid, tlast, tdata, pkt_cnt, exp_word(2'd3), m_pkt);
            end
            m_advance(2'd3); m_pkt++; m_beat++;
            if (i == 5) en = 1'b0;
            @(negedge ACLK);
        end
        n_tests++;
        if ({tvalid, pkt_cnt, beat_cnt} !== {1'b0, 32'd6, 32'd6}) begin
            n_fail++;
            $display("FAIL len0_end: got v=%b p=%0d n=%0d required v=0 p=6 n=6",
                     tvalid, pkt_cnt, beat_cnt);
        end
    endtask

    task automatic test_rst_midpacket();
        do_reset();
        @(negedge ACLK); en = 1'b1; mode = 2'd0; pkt_len = 16'd5; tready = 1'b1;
        @(negedge ACLK);
        @(negedge ACLK);
        @(negedge ACLK);
        n_tests++;
        if ({tvalid, tlast, tdata} !== {1'b1, 1'b0, 32'd2}) begin
            n_fail++;
            $display("FAIL rst_pre: got v=%b l=%b d=%h required v=1 l=0 d=00000002",
                     tvalid, tlast, tdata);
        end
        #2 RST = 1'b1;
        #1;
        n_tests++;
        if ({tvalid, busy, tlast, tdata, pkt_cnt, beat_cnt} !== 99'd0) begin
            n_fail++;
            $display("FAIL rst_mid: got v=%b b=%b l=%b d=%h p=%0d n=%0d required all zero",
                     tvalid, busy, tlast, tdata, pkt_cnt, beat_cnt);
        end
        @(negedge ACLK); RST = 1'b0; en = 1'b1;
        @(negedge ACLK); en = 1'b0;
        n_tests++;
        if ({tvalid, busy, tdata} !== {1'b1, 1'b1, 32'd0}) begin
            n_fail++;
            $display("FAIL rst_restart: got v=%b b=%b d=%h required v=1 b=1 d=00000000",
                     tvalid, busy, tdata);
        end
    endtask

    task automatic test_random();
        bit       r_busy = 1'b0;
        bit [1:0] r_mode = 2'd0;
        int       r_len = 0;
        int       r_idx = 0;
        int       r_last;
        do_reset();
        for (int cyc = 0; cyc < 460; cyc++) begin
            r_last = (r_len == 0) ? 0 : r_len - 1;
            n_tests++;
            if (r_busy) begin
                if ({tvalid, busy, tlast, tdata} !== {1'b1, 1'b1, (r_idx == r_last), exp_word(r_mode)}) begin
                    n_fail++;
                    $display("FAIL rand_beat_cyc%0d: got v=%b b=%b l=%b d=%h required v=1 b=1 l=%b d=%h",
                             cyc, tvalid, busy, tlast, tdata, (r_idx == r_last), exp_word(r_mode));
                end
            end else if ({tvalid, busy} !== 2'b00) begin
                n_fail++;
                $display("FAIL rand_idle_cyc%0d: got v=%b b=%b required v=0 b=0", cyc, tvalid, busy);
            end
            n_tests++;
            if ({pkt_cnt, beat_cnt} !== {32'(m_pkt), 32'(m_beat)}) begin
                n_fail++;
                $display("FAIL rand_cnt_cyc%0d: got p=%0d n=%0d required p=%0d n=%0d",
                         cyc, pkt_cnt, beat_cnt, m_pkt, m_beat);
            end
            en      = (cyc < 400) ? ($urandom_range(0, 3) != 0) : 1'b0;
            mode    = 2'($urandom_range(0, 3));
            pkt_len = 16'($urandom_range(0, 6));
            tready  = (cyc < 400) ? ($urandom_range(0, 2) != 0) : 1'b1;
            // Expected effect of the coming edge
            if (!r_busy) begin
                if (en) begin
                    r_busy = 1'b1; r_mode = mode; r_len = int'(pkt_len); r_idx = 0;
                end
            end else if (tready) begin
                m_advance(r_mode); m_beat++;
                if (r_idx == r_last) begin
                    m_pkt++;
                    if (en) begin
                        r_mode = mode; r_len = int'(pkt_len); r_idx = 0;
                    end else begin
                        r_busy = 1'b0;
                    end
                end else begin
                    r_idx++;
                end
            end
            @(negedge ACLK);
        end
        n_tests++;
        if (tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_drain: got v=%b required v=0", tvalid);
        end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_back_to_back();
        test_lfsr_stall();
        test_walk8();
        test_len0_alt();
        test_rst_midpacket();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
